// File: rtl/decoder_scan_sequencer_if.sv
// Control and decoder-drive signals between a scan controller and the sequencer.
interface decoder_scan_sequencer_if;
    logic       run;
    logic       hold;
    logic [2:0] last_idx;
    logic       B0;
    logic       B1;
    logic       B2;
    logic       E;
    logic       frame_done;

    modport master (
        output run,
        output hold,
        output last_idx,
        input  B0,
        input  B1,
        input  B2,
        input  E,
        input  frame_done
    );

    modport slave (
        input  run,
        input  hold,
        input  last_idx,
        output B0,
        output B1,
        output B2,
        output E,
        output frame_done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives a 3-to-8 decoder: per index a blanking gap (E low) then a dwell (E high),
// with the address only ever moving while E is low. Pulses frame_done at frame end.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       b, b_nxt;
    logic             e, e_nxt;
    logic             fd, fd_nxt;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            cnt   <= '0;
            b     <= 3'd0;
            e     <= 1'b0;
            fd    <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            b     <= b_nxt;
            e     <= e_nxt;
            fd    <= fd_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        b_nxt     = b;
        e_nxt     = e;
        fd_nxt    = 1'b0;

        if (!bus.run) begin
            // E drops on the stop edge; the address clears only one edge later
            state_nxt = ST_IDLE;
            e_nxt     = 1'b0;
            if (state == ST_IDLE) begin
                b_nxt = 3'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = BLANK_LOAD;
                    b_nxt     = 3'd0;
                    e_nxt     = 1'b0;
                end
                ST_BLANK: begin
                    b_nxt = idx;
                    e_nxt = 1'b0;
                    if (cnt == '0) begin
                        state_nxt = ST_DWELL;
                        cnt_nxt   = DWELL_LOAD;
                        e_nxt     = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_DWELL: begin
                    if (!bus.hold) begin
                        if (cnt == '0) begin
                            state_nxt = ST_BLANK;
                            cnt_nxt   = BLANK_LOAD;
                            e_nxt     = 1'b0;
                            // last_idx is only looked at here; a shrink below idx wraps
                            if (idx >= bus.last_idx) begin
                                idx_nxt = 3'd0;
                                fd_nxt  = 1'b1;
                            end else begin
                                idx_nxt = idx + 3'd1;
                            end
                        end else begin
                            cnt_nxt = cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    e_nxt     = 1'b0;
                end
            endcase
        end
    end

    assign bus.B0         = b[0];
    assign bus.B1         = b[1];
    assign bus.B2         = b[2];
    assign bus.E          = e;
    assign bus.frame_done = fd;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: directed scenarios plus a randomized run
// against a slot-position reference model.
module tb_decoder_scan_sequencer;

    localparam int DW   = 5;
    localparam int BL   = 2;
    localparam int SLOT = DW + BL;

    logic clk;
    logic rst_n;

    decoder_scan_sequencer_if bus();

    decoder_scan_sequencer #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] b_out;
    assign b_out = {bus.B2, bus.B1, bus.B0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position inside the current index slot (0..SLOT-1)
    logic       m_run;
    int         m_idx;
    int         m_pos;
    logic [2:0] m_b;
    logic       m_e;
    logic       m_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_idx <= 0;
            m_pos <= 0;
            m_b   <= 3'd0;
            m_e   <= 1'b0;
            m_fd  <= 1'b0;
        end else if (!bus.run) begin
            if (!m_run) m_b <= 3'd0;
            m_run <= 1'b0;
            m_e   <= 1'b0;
            m_fd  <= 1'b0;
        end else if (!m_run) begin
            m_run <= 1'b1;
            m_idx <= 0;
            m_pos <= 0;
            m_b   <= 3'd0;
            m_e   <= 1'b0;
            m_fd  <= 1'b0;
        end else if (m_pos >= BL && bus.hold) begin
            m_fd <= 1'b0;
        end else if (m_pos == SLOT - 1) begin
            m_fd  <= (m_idx >= int'(bus.last_idx));
            m_idx <= (m_idx >= int'(bus.last_idx)) ? 0 : m_idx + 1;
            m_pos <= 0;
            m_e   <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
            m_b   <= 3'(m_idx);
            m_e   <= (m_pos + 1 >= BL);
            m_fd  <= 1'b0;
        end
    end

    // No-ghosting invariant: address stable whenever E is high now or was last cycle
    logic [2:0] inv_b  = 3'd0;
    logic       inv_e  = 1'b0;
    logic       inv_ok = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && inv_ok && (inv_e || bus.E === 1'b1)) begin
            n_vec++;
            if (b_out !== inv_b) begin
                $display("FAIL invariant t=%0t: B moved %0d -> %0d around E high", $time, inv_b, b_out);
                n_err++;
            end
        end
        inv_b  <= b_out;
        inv_e  <= bus.E;
        inv_ok <= (rst_n === 1'b1);
    end

    task automatic restart(input logic [2:0] li);
        @(negedge clk);
        bus.run      = 1'b0;
        bus.hold     = 1'b0;
        bus.last_idx = li;
        @(negedge clk);
        @(negedge clk);
        bus.run = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.hold     = 1'b0;
        bus.last_idx = 3'd7;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({b_out, bus.E, bus.frame_done} !== 5'b0) begin
            $display("FAIL reset_state: B/E/fd=%0d/%0b/%0b expected 0/0/0", b_out, bus.E, bus.frame_done);
            n_err++;
        end
        rst_n   = 1'b1;
        bus.run = 1'b1;
        for (int i = 0; i < 100 && !(bus.E === 1'b1 && b_out === 3'd3); i++) @(negedge clk);
        n_vec++;
        if (!(bus.E === 1'b1 && b_out === 3'd3)) begin
            $display("FAIL reset_reach_idx3: timeout, B=%0d E=%0b", b_out, bus.E);
            n_err++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({b_out, bus.E, bus.frame_done} !== 5'b0) begin
            $display("FAIL reset_async: B/E/fd=%0d/%0b/%0b expected 0/0/0", b_out, bus.E, bus.frame_done);
            n_err++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.E !== (k == 3) || b_out !== 3'd0) begin
                $display("FAIL reset_first_rise edge %0d: E=%0b B=%0d expected E=%0b B=0", k, bus.E, b_out, (k == 3));
                n_err++;
            end
        end
    endtask

    task automatic test_scan(input logic [2:0] li, input int period);
        int   exp_idx = 0;
        int   n_fd    = 0;
        int   last_fd = -1;
        logic pe      = 1'b0;
        restart(li);
        for (int c = 0; c < 3 * period + 20; c++) begin
            @(negedge clk);
            if (bus.E === 1'b1 && !pe) begin
                n_vec++;
                if (b_out !== 3'(exp_idx)) begin
                    $display("FAIL scan_order li=%0d: B=%0d at E rise, expected %0d", li, b_out, exp_idx);
                    n_err++;
                end
                exp_idx = (exp_idx >= int'(li)) ? 0 : exp_idx + 1;
            end
            if (bus.frame_done === 1'b1) begin
                n_vec++;
                if (bus.E !== 1'b0 || pe !== 1'b1 || b_out !== li) begin
                    $display("FAIL scan_fd_edge li=%0d: E=%0b prevE=%0b B=%0d expected 0/1/%0d", li, bus.E, pe, b_out, li);
                    n_err++;
                end
                if (last_fd >= 0) begin
                    n_vec++;
                    if (c - last_fd != period) begin
                        $display("FAIL scan_period li=%0d: %0d cycles expected %0d", li, c - last_fd, period);
                        n_err++;
                    end
                end
                last_fd = c;
                n_fd++;
            end
            pe = bus.E;
        end
        n_vec++;
        if (n_fd < 3) begin
            $display("FAIL scan_fd_count li=%0d: %0d pulses expected at least 3", li, n_fd);
            n_err++;
        end
    endtask

    task automatic test_hold();
        int hi_len = 0;
        int lo_len = 0;
        restart(3'd7);
        for (int i = 0; i < 200 && !(bus.E === 1'b1 && b_out === 3'd4); i++) @(negedge clk);
        n_vec++;
        if (!(bus.E === 1'b1 && b_out === 3'd4)) begin
            $display("FAIL hold_reach_idx4: timeout, B=%0d E=%0b", b_out, bus.E);
            n_err++;
        end
        bus.hold = 1'b1;
        hi_len   = 1;
        for (int i = 1; i < 40 && bus.E === 1'b1; i++) begin
            @(negedge clk);
            if (i == 10) bus.hold = 1'b0;
            if (bus.E === 1'b1) begin
                hi_len++;
                n_vec++;
                if (b_out !== 3'd4) begin
                    $display("FAIL hold_addr: B=%0d during held dwell expected 4", b_out);
                    n_err++;
                end
            end
        end
        bus.hold = 1'b0;
        n_vec++;
        if (hi_len != 15) begin
            $display("FAIL hold_dwell_len: E high %0d cycles expected 15", hi_len);
            n_err++;
        end
        bus.hold = 1'b1;
        lo_len   = 1;
        for (int i = 0; i < 20 && bus.E !== 1'b1; i++) begin
            @(negedge clk);
            if (bus.E !== 1'b1) lo_len++;
        end
        bus.hold = 1'b0;
        n_vec++;
        if (lo_len != 2 || b_out !== 3'd5) begin
            $display("FAIL hold_in_blank: E low %0d cycles B=%0d expected 2 and 5", lo_len, b_out);
            n_err++;
        end
    endtask

    task automatic test_stop_restart();
        int n = 0;
        restart(3'd7);
        for (int i = 0; i < 200 && !(bus.E === 1'b1 && b_out === 3'd5); i++) @(negedge clk);
        n_vec++;
        if (!(bus.E === 1'b1 && b_out === 3'd5)) begin
            $display("FAIL stop_reach_idx5: timeout, B=%0d E=%0b", b_out, bus.E);
            n_err++;
        end
        bus.run = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({b_out, bus.E, bus.frame_done} !== {3'd5, 1'b0, 1'b0}) begin
            $display("FAIL stop_e_fall: B/E/fd=%0d/%0b/%0b expected 5/0/0", b_out, bus.E, bus.frame_done);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if ({b_out, bus.E, bus.frame_done} !== 5'b0) begin
            $display("FAIL stop_b_clear: B/E/fd=%0d/%0b/%0b expected 0/0/0", b_out, bus.E, bus.frame_done);
            n_err++;
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (bus.frame_done !== 1'b0 || bus.E !== 1'b0) begin
                $display("FAIL stop_parked: E=%0b fd=%0b expected 0/0", bus.E, bus.frame_done);
                n_err++;
            end
        end
        bus.run = 1'b1;
        for (int i = 0; i < 10 && bus.E !== 1'b1; i++) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 3 || bus.E !== 1'b1 || b_out !== 3'd0) begin
            $display("FAIL restart_idx0: rise after %0d edges B=%0d expected 3 edges B=0", n, b_out);
            n_err++;
        end
    endtask

    task automatic test_range_shrink();
        int   last_fd = 0;
        int   n_fd    = 0;
        logic seen    = 1'b0;
        logic pe      = 1'b1;
        restart(3'd7);
        for (int i = 0; i < 200 && !(bus.E === 1'b1 && b_out === 3'd5); i++) @(negedge clk);
        n_vec++;
        if (!(bus.E === 1'b1 && b_out === 3'd5)) begin
            $display("FAIL shrink_reach_idx5: timeout, B=%0d E=%0b", b_out, bus.E);
            n_err++;
        end
        bus.last_idx = 3'd2;
        for (int i = 0; i < 10 && bus.frame_done !== 1'b1; i++) @(negedge clk);
        n_vec++;
        if (bus.frame_done !== 1'b1 || b_out !== 3'd5 || bus.E !== 1'b0) begin
            $display("FAIL shrink_wrap_fd: fd=%0b B=%0d E=%0b expected 1/5/0", bus.frame_done, b_out, bus.E);
            n_err++;
        end
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (bus.E === 1'b1 && !pe && !seen) begin
                seen = 1'b1;
                n_vec++;
                if (b_out !== 3'd0) begin
                    $display("FAIL shrink_restart_idx: B=%0d at E rise expected 0", b_out);
                    n_err++;
                end
            end
            if (bus.frame_done === 1'b1) begin
                n_vec++;
                if (c - last_fd != 21) begin
                    $display("FAIL shrink_period: %0d cycles expected 21", c - last_fd);
                    n_err++;
                end
                last_fd = c;
                n_fd++;
            end
            pe = bus.E;
        end
        n_vec++;
        if (n_fd != 2 || !seen) begin
            $display("FAIL shrink_fd_count: %0d pulses rise_seen=%0b expected 2/1", n_fd, seen);
            n_err++;
        end
    endtask

    task automatic test_random();
        restart(3'(($urandom_range(0, 7))));
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_vec++;
            if ({b_out, bus.E, bus.frame_done} !== {m_b, m_e, m_fd}) begin
                $display("FAIL random cycle %0d: B/E/fd=%0d/%0b/%0b expected %0d/%0b/%0b",
                         c, b_out, bus.E, bus.frame_done, m_b, m_e, m_fd);
                n_err++;
            end
            bus.run  = ($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0;
            bus.hold = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 49) == 0) bus.last_idx = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        test_reset();
        test_scan(3'd7, 56);
        test_scan(3'd2, 21);
        test_scan(3'd0, 7);
        test_hold();
        test_stop_restart();
        test_range_shrink();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
